hazard_scoreboard_unit: RTL and testbench
=========================================

# hazard_scoreboard_unit

Parametrised successor to the pipeline hazard detection unit. It tracks outstanding register writes in a per-register countdown scoreboard, so the pipeline can host variable-latency producers (loads, multi-cycle multiply/divide) alongside single-cycle ALU ops. It sits beside the ID stage and drives the pipeline-register load enables and the bubble-insert control mux. It also exports a stall cause and a saturating stall-cycle counter for debug.

## Interface
- NUM_REGS, 32, architectural registers; x0 is never tracked
- NUM_SRC, 2, source-operand ports checked per issuing instruction
- LAT_W, 3, scoreboard counter width; every latency parameter must be < 2**LAT_W
- LOAD_LAT, 1, bubbles a dependent of a load needs with full forwarding
- MUL_LAT, 4, bubbles a dependent of a multi-cycle op needs
- CNT_W, 32, stall-counter width

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real (non-bubble) instruction
- id_rs  in  NUM_SRC x 5  source register indices
- id_rs_used  in  NUM_SRC  per-source "operand actually read" flags
- id_rd  in  5  destination register
- id_class  in  hazard_class_t  producer class: HC_NONE, HC_ALU, HC_LOAD, HC_MUL
- flush  in  1  branch/jump redirect; squashes the ID instruction this cycle
- stall_pipeline  in  1  memory not ready; freeze the whole pipeline
- ctrlmux_sel  out  1  1 = insert a bubble into ID/EX
- load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wr  out  1 each  pipeline-register enables
- sd  out  stall_cause_t  current stall cause
- stall_cycles  out  CNT_W  saturating count of stalled cycles

## Operation
- State: `busy[r]` is a LAT_W-bit counter for r = 1..NUM_REGS-1. A nonzero value means a dependent of r cannot issue yet.
- `src_hit` is true if any source i has `id_rs_used[i]`, `id_rs[i] != 0`, and `busy[id_rs[i]] != 0`.
- `waw` is true if `id_rd != 0`, the class is not HC_NONE, and the new latency is strictly less than `busy[id_rd]`. Stalling here keeps writeback in order.
- `hazard` = `id_valid & ~flush & (src_hit | waw)`.
- Output priority, evaluated combinationally every cycle:
  1. If `stall_pipeline`: all five load enables are 0, `ctrlmux_sel`=0, and `sd`=MEM_DELAY_STALL.
  2. Else if `hazard`: `load_pc`=0, `load_if_id`=0, `ctrlmux_sel`=1, all other enables are 1, and `sd` is RAW_LOAD, RAW_MULTICYCLE or WAW_ORDER. The cause comes from the class recorded for the offending register; RAW takes precedence over WAW.
  3. Else: all enables are 1, `ctrlmux_sel`=0, and `sd`=NO_STALL.
- Issue happens when `id_valid & ~flush & ~hazard & ~stall_pipeline`.
- Scoreboard update at each clk edge, when `stall_pipeline`=0:
  - Every nonzero `busy[r]` decrements by 1.
  - On issue with `id_rd != 0`: `busy[id_rd]` is set to LOAD_LAT for HC_LOAD, MUL_LAT for HC_MUL, and 0 for HC_ALU or HC_NONE.
  - When an issue and a decrement target the same register, the set wins.
- While `stall_pipeline`=1, every counter holds.
- A per-register 2-bit class tag is stored on set; it is used only for `sd`.
- `flush` never clears the scoreboard, because every issued instruction is older than the redirect. It only suppresses the ID issue and its stall.
- `stall_cycles` increments on any cycle where `sd != NO_STALL` and saturates at all-ones.

## Timing
- Outputs are combinational from the inputs and the scoreboard. They have zero-cycle latency, the same as the previous unit.
- Reset (rst=1 at an edge) clears every `busy`, every class tag, and `stall_cycles`. Outputs in the following cycle are all enables 1, `ctrlmux_sel`=0, and `sd`=NO_STALL, unless `stall_pipeline` is asserted.
- Load-use example with LOAD_LAT=1:
  - The load issues in cycle t, so `busy`=1 from t+1.
  - A dependent in ID at t+1 stalls (one bubble).
  - The counter reaches 0 at the t+1 edge, and the dependent issues at t+2.
- MUL example with MUL_LAT=4: a dependent in ID at t+1 sees four bubble cycles and issues at t+5.
- If `stall_pipeline` is asserted mid-countdown, the remaining bubble count is unchanged once it deasserts.
- Reset mid-countdown discards all pending hazards; the pipeline is flushed by the same reset.

## Structure
- Add to rv32i_types:
  - `hazard_class_t`
  - `stall_cause_t`, which supersedes `stall_debug` and keeps the existing NO_STALL/read_after_load/mem_delay_stall encodings as a prefix
  - the LOAD_LAT and MUL_LAT defaults
- One natural sub-module, `hazard_scoreboard_file`, holds the counter/tag array with a set port, a global decrement/hold, and NUM_SRC+1 combinational read ports. The top level holds the priority logic and the stall counter.

## Test plan
- Load x5 followed immediately by `add x6,x5,x1` → one cycle with `ctrlmux_sel`=1, `load_pc`=0 and `sd`=RAW_LOAD; the add issues at t+2.
- `mul x7` followed by a dependent `sub x8,x7,x7` (MUL_LAT=4) → exactly 4 stall cycles, and `stall_cycles` increases by 4.
- The same load-use pair with `stall_pipeline` held for 3 cycles mid-bubble → all enables 0 for those 3 cycles, then exactly the remaining 1 bubble.
- `mul x9` then `addi x9` (ALU, latency 0 < busy) → WAW_ORDER stall until `busy[x9]`=0, then the addi issues.
- `flush`=1 while a dependent sits in ID → no stall and no scoreboard set; rd=x0 loads and unused sources (`id_rs_used`=0) never stall.
- Assert `rst` with `busy[x5]`=3 → the next cycle shows no stall for an x5 reader, and `stall_cycles`=0.

Source files
------------

// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared types and latency defaults for the scoreboard-based hazard unit.
// stall_cause_t keeps the older stall_debug encodings (0..2) as a prefix.
package hazard_scoreboard_unit_pkg;

    typedef enum logic [1:0] {
        HC_NONE = 2'd0,
        HC_ALU  = 2'd1,
        HC_LOAD = 2'd2,
        HC_MUL  = 2'd3
    } hazard_class_t;

    typedef enum logic [2:0] {
        NO_STALL        = 3'd0,
        RAW_LOAD        = 3'd1,
        MEM_DELAY_STALL = 3'd2,
        RAW_MULTICYCLE  = 3'd3,
        WAW_ORDER       = 3'd4
    } stall_cause_t;

    localparam int unsigned LOAD_LAT_DEFAULT = 1;
    localparam int unsigned MUL_LAT_DEFAULT  = 4;
    localparam int unsigned REG_IDX_W        = 5;

endpackage

// File: rtl/hazard_scoreboard_file.sv
// Per-register countdown counters plus producer-class tags, with one set port,
// a global decrement/hold and NUM_PORTS combinational read ports.
module hazard_scoreboard_file
    import hazard_scoreboard_unit_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned LAT_W     = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           hold,
    input  logic                           set_en,
    input  logic [REG_IDX_W-1:0]           set_idx,
    input  logic [LAT_W-1:0]               set_lat,
    input  hazard_class_t                  set_class,
    input  logic [NUM_PORTS*REG_IDX_W-1:0] rd_idx,
    output logic [NUM_PORTS*LAT_W-1:0]     rd_cnt,
    output logic [NUM_PORTS*2-1:0]         rd_class
);

    logic [LAT_W-1:0] busy_q [NUM_REGS];
    logic [LAT_W-1:0] busy_d [NUM_REGS];
    hazard_class_t    tag_q  [NUM_REGS];
    hazard_class_t    tag_d  [NUM_REGS];

    always_comb begin
        busy_d[0] = '0;
        tag_d[0]  = HC_NONE;
        for (int r = 1; r < NUM_REGS; r++) begin
            busy_d[r] = busy_q[r];
            tag_d[r]  = tag_q[r];
            if (!hold) begin
                if (busy_q[r] != '0) begin
                    busy_d[r] = busy_q[r] - 1'b1;
                end
                // A fresh set overrides the decrement of the same cycle.
                if (set_en && (int'(set_idx) == r)) begin
                    busy_d[r] = set_lat;
                    tag_d[r]  = set_class;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                busy_q[r] <= '0;
                tag_q[r]  <= HC_NONE;
            end
        end else begin
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

    always_comb begin
        logic [REG_IDX_W-1:0] idx;
        idx      = '0;
        rd_cnt   = '0;
        rd_class = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            idx = rd_idx[p*REG_IDX_W +: REG_IDX_W];
            if (int'(idx) < NUM_REGS) begin
                rd_cnt[p*LAT_W +: LAT_W] = busy_q[idx];
                rd_class[p*2 +: 2]       = tag_q[idx];
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// ID-stage hazard unit: scoreboard lookup, stall priority, pipeline enables,
// stall cause and a saturating stalled-cycle counter.
module hazard_scoreboard_unit
    import hazard_scoreboard_unit_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned LAT_W    = 3,
    parameter int unsigned LOAD_LAT = LOAD_LAT_DEFAULT,
    parameter int unsigned MUL_LAT  = MUL_LAT_DEFAULT,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         id_valid,
    input  logic [NUM_SRC*REG_IDX_W-1:0] id_rs,
    input  logic [NUM_SRC-1:0]           id_rs_used,
    input  logic [REG_IDX_W-1:0]         id_rd,
    input  hazard_class_t                id_class,
    input  logic                         flush,
    input  logic                         stall_pipeline,
    output logic                         ctrlmux_sel,
    output logic                         load_pc,
    output logic                         load_if_id,
    output logic                         load_id_ex,
    output logic                         load_ex_mem,
    output logic                         load_mem_wr,
    output stall_cause_t                 sd,
    output logic [CNT_W-1:0]             stall_cycles
);

    localparam int unsigned NUM_PORTS = NUM_SRC + 1;

    logic [NUM_PORTS*REG_IDX_W-1:0] rd_idx;
    logic [NUM_PORTS*LAT_W-1:0]     rd_cnt;
    logic [NUM_PORTS*2-1:0]         rd_class;
    logic [LAT_W-1:0]               new_lat;
    logic                           src_hit;
    hazard_class_t                  raw_class;
    logic                           waw;
    logic                           hazard;
    logic                           set_en;
    logic [CNT_W-1:0]               stall_cycles_q;
    logic [CNT_W-1:0]               stall_cycles_d;

    // The destination occupies the last read port, after the sources.
    assign rd_idx = {id_rd, id_rs};

    always_comb begin
        new_lat = '0;
        unique case (id_class)
            HC_LOAD: new_lat = LAT_W'(LOAD_LAT);
            HC_MUL:  new_lat = LAT_W'(MUL_LAT);
            default: new_lat = '0;
        endcase
    end

    always_comb begin
        src_hit   = 1'b0;
        raw_class = HC_NONE;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!src_hit && id_rs_used[i] && (id_rs[i*REG_IDX_W +: REG_IDX_W] != '0) &&
                (rd_cnt[i*LAT_W +: LAT_W] != '0)) begin
                src_hit   = 1'b1;
                raw_class = hazard_class_t'(rd_class[i*2 +: 2]);
            end
        end
    end

    assign waw = (id_rd != '0) && (id_class != HC_NONE) &&
                 (new_lat < rd_cnt[NUM_SRC*LAT_W +: LAT_W]);
    assign hazard = id_valid && !flush && (src_hit || waw);
    assign set_en = id_valid && !flush && !hazard && !stall_pipeline && (id_rd != '0);

    hazard_scoreboard_file #(
        .NUM_REGS  (NUM_REGS),
        .NUM_PORTS (NUM_PORTS),
        .LAT_W     (LAT_W)
    ) u_file (
        .clk       (clk),
        .rst       (rst),
        .hold      (stall_pipeline),
        .set_en    (set_en),
        .set_idx   (id_rd),
        .set_lat   (new_lat),
        .set_class (id_class),
        .rd_idx    (rd_idx),
        .rd_cnt    (rd_cnt),
        .rd_class  (rd_class)
    );

    always_comb begin
        ctrlmux_sel = 1'b0;
        load_pc     = 1'b1;
        load_if_id  = 1'b1;
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wr = 1'b1;
        sd          = NO_STALL;
        if (stall_pipeline) begin
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            load_id_ex  = 1'b0;
            load_ex_mem = 1'b0;
            load_mem_wr = 1'b0;
            sd          = MEM_DELAY_STALL;
        end else if (hazard) begin
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            ctrlmux_sel = 1'b1;
            if (src_hit) begin
                sd = (raw_class == HC_LOAD) ? RAW_LOAD : RAW_MULTICYCLE;
            end else begin
                sd = WAW_ORDER;
            end
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if ((sd != NO_STALL) && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench: a cycle-by-cycle vector table plus hand-written sequences for
// multiply-dependent stalls, counter saturation and reset mid-countdown.
module tb_hazard_scoreboard_unit;
    import hazard_scoreboard_unit_pkg::*;

    localparam logic [4:0] EN_ALL = 5'b11111;
    localparam logic [4:0] EN_HAZ = 5'b00111;
    localparam logic [4:0] EN_OFF = 5'b00000;
    localparam int NVEC = 36;

    typedef struct packed {
        logic          valid;
        logic [4:0]    rs0;
        logic [4:0]    rs1;
        logic [1:0]    used;
        logic [4:0]    rd;
        hazard_class_t cls;
        logic          flush;
        logic          stall;
        logic          exp_mux;
        logic [4:0]    exp_en;
        stall_cause_t  exp_sd;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          id_valid;
    logic [9:0]    id_rs;
    logic [1:0]    id_rs_used;
    logic [4:0]    id_rd;
    hazard_class_t id_class;
    logic          flush;
    logic          stall_pipeline;

    logic          ctrlmux_sel, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wr;
    stall_cause_t  sd;
    logic [31:0]   stall_cycles;

    logic          s_mux, s_pc, s_ifid, s_idex, s_exmem, s_memwr;
    stall_cause_t  s_sd;
    logic [1:0]    s_cycles;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs [NVEC];

    hazard_scoreboard_unit dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_rs          (id_rs),
        .id_rs_used     (id_rs_used),
        .id_rd          (id_rd),
        .id_class       (id_class),
        .flush          (flush),
        .stall_pipeline (stall_pipeline),
        .ctrlmux_sel    (ctrlmux_sel),
        .load_pc        (load_pc),
        .load_if_id     (load_if_id),
        .load_id_ex     (load_id_ex),
        .load_ex_mem    (load_ex_mem),
        .load_mem_wr    (load_mem_wr),
        .sd             (sd),
        .stall_cycles   (stall_cycles)
    );

    // Narrow counter copy so saturation is reachable.
    hazard_scoreboard_unit #(.CNT_W(2)) dut_sat (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_rs          (id_rs),
        .id_rs_used     (id_rs_used),
        .id_rd          (id_rd),
        .id_class       (id_class),
        .flush          (flush),
        .stall_pipeline (stall_pipeline),
        .ctrlmux_sel    (s_mux),
        .load_pc        (s_pc),
        .load_if_id     (s_ifid),
        .load_id_ex     (s_idex),
        .load_ex_mem    (s_exmem),
        .load_mem_wr    (s_memwr),
        .sd             (s_sd),
        .stall_cycles   (s_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(logic v, logic [4:0] rs0, logic [4:0] rs1, logic [1:0] used,
                                logic [4:0] rd, hazard_class_t cls, logic fl, logic st,
                                logic mux, logic [4:0] en, stall_cause_t c);
        vec_t t;
        t.valid = v;   t.rs0 = rs0;  t.rs1 = rs1;  t.used = used;  t.rd = rd;
        t.cls = cls;   t.flush = fl; t.stall = st;
        t.exp_mux = mux; t.exp_en = en; t.exp_sd = c;
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(vec_t v);
        id_valid       = v.valid;
        id_rs          = {v.rs1, v.rs0};
        id_rs_used     = v.used;
        id_rd          = v.rd;
        id_class       = v.cls;
        flush          = v.flush;
        stall_pipeline = v.stall;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs();
        return {23'd0, ctrlmux_sel, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wr, sd};
    endfunction

    initial begin
        int n_stall;
        int base;
        bit done;

        vecs[0]  = mk(0,  0, 0, 2'b00,  0, HC_NONE, 0, 0, 0, EN_ALL, NO_STALL);
        vecs[1]  = mk(1,  1, 0, 2'b01,  5, HC_LOAD, 0, 0, 0, EN_ALL, NO_STALL);
        vecs[2]  = mk(1,  5, 1, 2'b11,  6, HC_ALU,  0, 0, 1, EN_HAZ, RAW_LOAD);
        vecs[3]  = mk(1,  5, 1, 2'b11,  6, HC_ALU,  0, 0, 0, EN_ALL, NO_STALL);
        vecs[4]  = mk(1,  1, 2, 2'b11,  7, HC_MUL,  0, 0, 0, EN_ALL, NO_STALL);
        for (int i = 5; i <= 8; i++)
            vecs[i] = mk(1, 7, 7, 2'b11, 8, HC_ALU, 0, 0, 1, EN_HAZ, RAW_MULTICYCLE);
        vecs[9]  = mk(1,  7, 7, 2'b11,  8, HC_ALU,  0, 0, 0, EN_ALL, NO_STALL);
        vecs[10] = mk(1,  1, 0, 2'b01,  5, HC_LOAD, 0, 0, 0, EN_ALL, NO_STALL);
        for (int i = 11; i <= 13; i++)
            vecs[i] = mk(1, 5, 1, 2'b11, 6, HC_ALU, 0, 1, 0, EN_OFF, MEM_DELAY_STALL);
        vecs[14] = mk(1,  5, 1, 2'b11,  6, HC_ALU,  0, 0, 1, EN_HAZ, RAW_LOAD);
        vecs[15] = mk(1,  5, 1, 2'b11,  6, HC_ALU,  0, 0, 0, EN_ALL, NO_STALL);
        vecs[16] = mk(1,  1, 2, 2'b11,  9, HC_MUL,  0, 0, 0, EN_ALL, NO_STALL);
        for (int i = 17; i <= 20; i++)
            vecs[i] = mk(1, 1, 0, 2'b01, 9, HC_ALU, 0, 0, 1, EN_HAZ, WAW_ORDER);
        vecs[21] = mk(1,  1, 0, 2'b01,  9, HC_ALU,  0, 0, 0, EN_ALL, NO_STALL);
        vecs[22] = mk(1,  1, 0, 2'b01, 10, HC_LOAD, 0, 0, 0, EN_ALL, NO_STALL);
        vecs[23] = mk(1, 10, 0, 2'b01, 11, HC_ALU,  1, 0, 0, EN_ALL, NO_STALL);
        vecs[24] = mk(1,  1, 0, 2'b01, 11, HC_LOAD, 1, 0, 0, EN_ALL, NO_STALL);
        vecs[25] = mk(1, 11, 0, 2'b01, 12, HC_ALU,  0, 0, 0, EN_ALL, NO_STALL);
        vecs[26] = mk(1,  1, 0, 2'b01,  0, HC_LOAD, 0, 0, 0, EN_ALL, NO_STALL);
        vecs[27] = mk(1,  0, 0, 2'b11, 13, HC_ALU,  0, 0, 0, EN_ALL, NO_STALL);
        vecs[28] = mk(1,  1, 0, 2'b01, 12, HC_LOAD, 0, 0, 0, EN_ALL, NO_STALL);
        vecs[29] = mk(1, 12, 12, 2'b00, 14, HC_ALU, 0, 0, 0, EN_ALL, NO_STALL);
        vecs[30] = mk(1,  1, 0, 2'b01, 13, HC_LOAD, 0, 0, 0, EN_ALL, NO_STALL);
        vecs[31] = mk(1, 13, 1, 2'b10, 14, HC_ALU,  0, 0, 0, EN_ALL, NO_STALL);
        vecs[32] = mk(1,  1, 0, 2'b01, 14, HC_LOAD, 0, 0, 0, EN_ALL, NO_STALL);
        vecs[33] = mk(0, 14, 14, 2'b11, 15, HC_ALU, 0, 0, 0, EN_ALL, NO_STALL);
        vecs[34] = mk(1,  1, 2, 2'b11, 15, HC_MUL,  0, 0, 0, EN_ALL, NO_STALL);
        vecs[35] = mk(1, 15, 0, 2'b01, 15, HC_ALU,  0, 0, 1, EN_HAZ, RAW_MULTICYCLE);

        rst = 1'b1;
        apply(vecs[0]);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        chk("reset_stall_cycles", stall_cycles, 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i]);
            #2;
            chk($sformatf("vec%0d_outputs", i), outs(),
                {23'd0, vecs[i].exp_mux, vecs[i].exp_en, vecs[i].exp_sd});
            step();
        end
        // Stalled rows: 2, 5-8, 11-13, 14, 17-20, 35.
        chk("table_stall_cycles", stall_cycles, 32'd14);
        chk("saturated_stall_cycles", {30'd0, s_cycles}, 32'd3);

        // mul x20 then a dependent: four bubbles, counter advances by four.
        apply(mk(1, 1, 2, 2'b11, 20, HC_MUL, 0, 0, 0, EN_ALL, NO_STALL));
        #2;
        chk("mul_issue_mux", {31'd0, ctrlmux_sel}, 32'd0);
        step();
        base = stall_cycles;
        apply(mk(1, 20, 20, 2'b11, 21, HC_ALU, 0, 0, 0, EN_ALL, NO_STALL));
        n_stall = 0;
        done = 1'b0;
        for (int k = 0; k < 10 && !done; k++) begin
            #2;
            if (ctrlmux_sel) n_stall++;
            else done = 1'b1;
            step();
        end
        chk("mul_dep_issued", {31'd0, done}, 32'd1);
        chk("mul_dep_bubbles", n_stall, 32'd4);
        chk("mul_dep_stall_delta", stall_cycles - base, 32'd4);

        // Reset while busy[x5] = 3 discards the pending hazard and the counter.
        apply(mk(1, 1, 2, 2'b11, 5, HC_MUL, 0, 0, 0, EN_ALL, NO_STALL));
        step();
        apply(vecs[0]);
        step();
        apply(mk(1, 5, 0, 2'b01, 6, HC_ALU, 0, 0, 0, EN_ALL, NO_STALL));
        #2;
        chk("pre_reset_x5_busy", {31'd0, ctrlmux_sel}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #2;
        chk("post_reset_outputs", outs(), {23'd0, 1'b0, EN_ALL, NO_STALL});
        chk("post_reset_stall_cycles", stall_cycles, 32'd0);
        chk("post_reset_sat_cycles", {30'd0, s_cycles}, 32'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
